// File: rtl/alsu_result_collector.sv
// alsu_result_collector: tags ALSU results, flags invalid ops, buffers them in a FWFT FIFO
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   issue_valid, issue_tag     command issued to the ALSU this cycle and its tag
//   alsu_out, alsu_leds        ALSU result and LED outputs
//   res_valid, res_ready       head-entry handshake
//   res_data                   {tag, err, out} of the head entry (0 while empty)
//   full, level                occupancy status
//   overflow_cnt               saturating count of results dropped on a full FIFO
module alsu_result_collector #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic [TAG_W-1:0]         issue_tag,
  input  logic [5:0]               alsu_out,
  input  logic [15:0]              alsu_leds,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [TAG_W+6:0]         res_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               overflow_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic             s1_v, s2_v;
  logic [TAG_W-1:0] s1_t, s2_t;
  logic [15:0]      leds_q;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [TAG_W+6:0] mem [DEPTH];
  logic             pop, push, drop;
  assign pop       = res_valid && res_ready;
  // a full FIFO still accepts a record when the head leaves on the same edge
  assign push      = s2_v && (!full || pop);
  assign drop      = s2_v && full && !pop;
  assign res_valid = count != '0;
  assign full      = count == (AW+1)'(DEPTH);
  assign level     = count;
  assign res_data  = res_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_v         <= 1'b0;
      s2_v         <= 1'b0;
      s1_t         <= '0;
      s2_t         <= '0;
      leds_q       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_cnt <= '0;
    end else begin
      s1_v   <= issue_valid;
      s1_t   <= issue_tag;
      s2_v   <= s1_v;
      s2_t   <= s1_t;
      leds_q <= alsu_leds;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count  <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (drop && overflow_cnt != 8'hff) overflow_cnt <= overflow_cnt + 8'd1;
    end
  // storage needs no reset: res_data is masked while the FIFO is empty
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {s2_t, alsu_leds != leds_q, alsu_out};
endmodule

// File: tb/tb_alsu_result_collector.sv
// tb_alsu_result_collector: randomized and directed checks against a queue-based reference model
module tb_alsu_result_collector;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [3:0]  issue_tag = '0;
  logic [5:0]  alsu_out = '0;
  logic [15:0] alsu_leds = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [10:0] res_data;
  logic        full;
  logic [2:0]  level;
  logic [7:0]  overflow_cnt;
  int checks = 0;
  int failures = 0;
  typedef struct {int due; logic [3:0] tag;} pend_t;
  pend_t       pend[$];
  logic [10:0] q[$];
  int          ovf = 0;
  int          cyc = 0;
  logic [15:0] prev_leds = '0;
  logic [15:0] cur_leds = '0;
  alsu_result_collector #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_tag(issue_tag),
    .alsu_out(alsu_out), .alsu_leds(alsu_leds), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .full(full), .level(level),
    .overflow_cnt(overflow_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, obs, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    pend.delete();
    ovf = 0;
    prev_leds = '0;
  endtask
  task automatic compare();
    chk("valid", res_valid, q.size() != 0);
    chk("level", level, q.size());
    chk("full", full, q.size() == 4);
    chk("ovf", overflow_cnt, ovf);
    if (q.size() != 0) chk("data", res_data, q[0]);
  endtask
  // called at a falling edge: check state, drive inputs, model the rising edge, return at next falling edge
  task automatic step(input logic iv, input logic [3:0] tg, input logic [5:0] o,
                      input logic [15:0] l, input logic rdy);
    bit pop;
    compare();
    issue_valid = iv;
    issue_tag   = tg;
    alsu_out    = o;
    alsu_leds   = l;
    res_ready   = rdy;
    @(posedge clk);
    pop = rdy && q.size() != 0;
    if (pop) void'(q.pop_front());
    if (pend.size() != 0 && pend[0].due == cyc) begin
      if (q.size() < 4) q.push_back({pend[0].tag, l != prev_leds, o});
      else if (ovf < 255) ovf++;
      void'(pend.pop_front());
    end
    if (iv) pend.push_back('{cyc + 2, tg});
    prev_leds = l;
    cyc++;
    @(negedge clk);
  endtask
  task automatic check_reset_outputs(input string nm);
    chk({nm, "_valid"}, res_valid, 0);
    chk({nm, "_full"}, full, 0);
    chk({nm, "_level"}, level, 0);
    chk({nm, "_data"}, res_data, 0);
    chk({nm, "_ovf"}, overflow_cnt, 0);
  endtask
  initial begin
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1, 4'd3, 6'd0, cur_leds, 1);
    step(0, 4'd0, 6'd0, cur_leds, 1);
    step(0, 4'd0, 6'd5, cur_leds, 1);
    chk("add_v", res_valid, 1);
    chk("add_d", res_data, {4'd3, 1'b0, 6'd5});
    step(0, 4'd0, 6'd5, cur_leds, 1);
    chk("add_gone", res_valid, 0);
    step(1, 4'd7, 6'd5, cur_leds, 1);
    step(1, 4'd8, 6'd5, cur_leds, 1);
    cur_leds = ~cur_leds;
    step(0, 4'd0, 6'd0, cur_leds, 1);
    chk("inv_d", res_data, {4'd7, 1'b1, 6'd0});
    step(0, 4'd0, 6'd6, cur_leds, 1);
    chk("xor_d", res_data, {4'd8, 1'b0, 6'd6});
    step(0, 4'd0, 6'd6, cur_leds, 1);
    for (int i = 0; i < 6; i++) step(1, 4'(i), 6'(i + 10), cur_leds, 0);
    step(0, 4'd0, 6'd0, cur_leds, 0);
    step(0, 4'd0, 6'd0, cur_leds, 0);
    chk("ov_full", full, 1);
    chk("ov_level", level, 4);
    chk("ov_cnt", overflow_cnt, 2);
    for (int i = 0; i < 4; i++) begin
      chk("drain_tag", res_data[10:7], i);
      step(0, 4'd0, 6'd0, cur_leds, 1);
    end
    chk("drained", res_valid, 0);
    for (int i = 0; i < 6; i++) step(1, 4'(i), 6'(i), cur_leds, 0);
    chk("pp_full", full, 1);
    for (int i = 6; i < 14; i++) begin
      step(1, 4'(i), 6'(i), cur_leds, 1);
      chk("pp_level", level, 4);
      chk("pp_ovf", overflow_cnt, 2);
    end
    for (int i = 0; i < 8; i++) step(0, 4'd0, 6'd0, cur_leds, 1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) cur_leds = 16'($urandom);
      step($urandom_range(0, 3) != 0, 4'($urandom), 6'($urandom), cur_leds,
           $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 305; i++) step(1, 4'($urandom), 6'($urandom), cur_leds, 0);
    chk("sat", overflow_cnt, 255);
    for (int i = 0; i < 8; i++) step(0, 4'd0, 6'd0, cur_leds, 1);
    step(1, 4'd1, 6'd0, cur_leds, 0);
    step(1, 4'd2, 6'd0, cur_leds, 0);
    step(1, 4'd3, 6'd1, cur_leds, 0);
    step(0, 4'd0, 6'd2, cur_leds, 0);
    chk("mid_level", level, 2);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid");
    issue_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("held");
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) step(0, 4'd0, 6'd3, cur_leds, 1);
    chk("no_stale", res_valid, 0);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) cur_leds = 16'($urandom);
      step($urandom_range(0, 1) != 0, 4'($urandom), 6'($urandom), cur_leds,
           $urandom_range(0, 1) != 0);
    end
    compare();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alsu_result_collector.md
# alsu_result_collector

Captures every result the ALSU produces, pairs it with the tag of the command that caused it, flags invalid-operation results, and buffers the records in a small first-word-fall-through FIFO with a valid/ready output. It is the read-side counterpart of the ALSU: the command source pulses `issue_valid` with a tag in the same cycle it drives opcode/A/B/control to the ALSU. The collector tracks the ALSU's fixed two-register latency and hands tagged results to a downstream consumer, such as a checker or a host readback.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `TAG_W`, 4: command tag width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `issue_valid`  in  1  a command is presented to the ALSU this cycle.
- `issue_tag`  in  TAG_W  tag of that command.
- `alsu_out`  in  6  ALSU `out`.
- `alsu_leds`  in  16  ALSU `leds`.
- `res_valid`  out  1  FIFO non-empty.
- `res_ready`  in  1  consumer accepts the head entry.
- `res_data`  out  TAG_W+7  `{tag, err, out[5:0]}` of the head entry.
- `full`  out  1  FIFO holds DEPTH entries.
- `level`  out  clog2(DEPTH)+1  entries held.
- `overflow_cnt`  out  8  results dropped because the FIFO was full; saturates at 255.

## Operation
- **Tag pipeline.** A two-stage shift register holds `{valid, tag}`.
  - Stage 1 loads `{issue_valid, issue_tag}` every edge.
  - Stage 2 loads stage 1 every edge.
- **LED history.** `leds_q` loads `alsu_leds` every edge.
- **Capture.** On an edge where stage 2 is valid, push one record:
  - `tag` = stage-2 tag.
  - `out` = `alsu_out`.
  - `err` = (`alsu_leds != leds_q`), i.e. the LEDs toggled on the edge that produced this result. This covers opcodes 6/7 and reduction on opcodes 2–5.
- **FIFO.**
  - Circular buffer with `wr_ptr`/`rd_ptr` and a count.
  - Head is presented combinationally on `res_data`.
  - `res_valid` = (count != 0).
  - Pop when `res_valid && res_ready`.
  - `res_data` is don't-care while `res_valid` = 0.
- **Push and pop rules.**
  - Push and pop on the same edge: both happen and the count is unchanged, including when full.
  - Push while full without a pop: the record is dropped, the FIFO is untouched, and `overflow_cnt` increments (holds at 255).
  - Pop while empty is impossible, because `res_valid` = 0.
- Pointers wrap modulo DEPTH.
- `full` = (count == DEPTH). `level` = count.
- **Reset** (asynchronous, any time):
  - Both tag stages invalid, `leds_q` = 0, pointers and count = 0, `overflow_cnt` = 0.
  - Outputs: `res_valid` = 0, `full` = 0, `level` = 0, `res_data` = 0.
  - Results in flight or buffered are discarded. The first capture possible after deassertion belongs to a command issued at or after the first post-reset edge.

## Timing
- Issue sampled at edge N. The ALSU registers inputs at N and updates `out`/`leds` at N+1. The record is pushed at edge N+2, and `res_valid` rises after N+2 if the FIFO was empty.
- Issue-to-`res_valid` latency: 2 edges.
- Throughput: one result per cycle, sustained while `res_ready` = 1.
- `res_ready` may be held high continuously. `res_data` may change only after a pop or on a push into an empty FIFO.
- `level` and `full` reflect the state after the edge. There is no combinational path from `res_ready` to `full`.

## Test plan
- **Single add.** Issue tag 3 with opcode 2, A=3, B=2, cin=0, no bypass or reduction, `res_ready` = 1.
  - `res_valid` is high for one cycle, two edges after issue.
  - `res_data` = `{3, 0, 6'd5}`.
- **Invalid opcode.** Issue tag 7 with opcode 6.
  - `res_data` = `{7, 1, 6'd0}`.
  - The following valid XOR (A=5, B=3, tag 8) gives `{8, 0, 6'd6}`.
- **Overflow with consumer stalled.** `res_ready` = 0, six back-to-back issues with tags 0–5.
  - `full` = 1 and `level` = 4.
  - `overflow_cnt` = 2.
  - Draining yields tags 0, 1, 2, 3 in order.
- **Push and pop at the same time when full.**
  - Setup: FIFO full, `res_ready` = 1, and a new issue arrives every cycle.
  - `level` stays at 4, `overflow_cnt` is unchanged, and tags emerge in issue order.
- **Reset mid-operation.** Pulse `rst_n` low between issue and capture, with 2 entries buffered.
  - All outputs read 0 immediately, asynchronously.
  - No stale record appears after release.
- **Overflow saturation.** Drop 300 results while `res_ready` = 0.
  - `overflow_cnt` = 255.
  - Reset clears it to 0.
